// File: rtl/demo_audio_sequencer.sv
// Demo timeline and 1-bit audio sequencer: frame/line tick driven timer, melody
// square wave, LFSR noise snare and kick envelope, mixed into registered PWM audio.
module demo_audio_sequencer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          NOISE_DIV = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        pause,
  output logic [11:0] frame_count,
  output logic [2:0]  part,
  output logic        frame_strobe,
  output logic [3:0]  note_idx,
  output logic        audio
);

  logic [12:0] r_timer;
  logic [8:0]  r_cnt;
  logic        r_note;
  logic [15:0] r_lfsr;
  logic [2:0]  r_div;
  logic        r_audio;
  logic        r_strobe;

  logic        w_frame_tick, w_line_tick;
  logic [8:0]  w_freq;
  logic [4:0]  w_env_a, w_env_b;
  logic        w_kick, w_snare, w_lead;
  logic [15:0] w_lfsr_next;
  logic [2:0]  w_div_last;

  assign w_line_tick  = (hpos == 10'd0) && !pause;
  assign w_frame_tick = w_line_tick && (vpos == 10'd0);
  assign w_div_last   = 3'(NOISE_DIV - 1);

  assign frame_count  = r_timer[12:1];
  assign part         = r_timer[10:8];
  assign note_idx     = r_timer[8:5];
  assign frame_strobe = r_strobe;
  assign audio        = r_audio;

  // Melody half-periods in lines
  always_comb begin
    w_freq = 9'd151;
    case (note_idx)
      4'd0:  w_freq = 9'd151;
      4'd1:  w_freq = 9'd26;
      4'd2:  w_freq = 9'd40;
      4'd3:  w_freq = 9'd60;
      4'd4:  w_freq = 9'd90;
      4'd5:  w_freq = 9'd143;
      4'd6:  w_freq = 9'd23;
      4'd7:  w_freq = 9'd35;
      4'd8:  w_freq = 9'd151;
      4'd9:  w_freq = 9'd23;
      4'd10: w_freq = 9'd35;
      4'd11: w_freq = 9'd151;
      4'd12: w_freq = 9'd143;
      4'd13: w_freq = 9'd151;
      4'd14: w_freq = 9'd40;
      4'd15: w_freq = 9'd60;
      default: w_freq = 9'd151;
    endcase
  end

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  assign w_env_a = 5'd31 - r_timer[4:0];
  assign w_env_b = 5'd31 - {r_timer[3:0], 1'b0};

  // Voices gate on the beam column, so each one is a pulse whose width decays with the envelope
  assign w_kick  = (vpos < 10'd255) && (hpos < {5'd0, w_env_a});
  assign w_snare = r_lfsr[0] && (hpos >= 10'd32) && (hpos < 10'd32 + {5'd0, w_env_b})
                   && (r_timer[5:4] == 2'b10);
  assign w_lead  = r_note && (hpos >= 10'd64) && (hpos < 10'd64 + {5'd0, w_env_b});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer  <= '0;
      r_cnt    <= '0;
      r_note   <= 1'b0;
      r_lfsr   <= LFSR_SEED;
      r_div    <= '0;
      r_audio  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_frame_tick;
      r_audio  <= (w_kick | w_snare | w_lead) & !pause;
      if (w_frame_tick)
        r_timer <= r_timer + 13'd1;
      if (w_line_tick) begin
        // No reload on a note change: the running count is compared against the new freq
        if (r_cnt > w_freq) begin
          r_cnt  <= '0;
          r_note <= ~r_note;
        end else begin
          r_cnt <= r_cnt + 9'd1;
        end
        if (r_div == w_div_last) begin
          r_div  <= '0;
          r_lfsr <= w_lfsr_next;
        end else begin
          r_div <= r_div + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demo_audio_sequencer.sv
// Scoreboard bench for demo_audio_sequencer: a frame/line-level reference model
// predicts every post-edge output; a negedge monitor pops and compares.
module tb_demo_audio_sequencer;

  localparam int NDIV = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos, vpos;
  logic        pause;
  logic [11:0] frame_count;
  logic [2:0]  part;
  logic        frame_strobe;
  logic [3:0]  note_idx;
  logic        audio;

  demo_audio_sequencer #(.LFSR_SEED(SEED), .NOISE_DIV(NDIV)) dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .pause(pause),
    .frame_count(frame_count), .part(part), .frame_strobe(frame_strobe),
    .note_idx(note_idx), .audio(audio)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fc; int prt; int nidx; int strobe; int aud; int note; int lfsr;
  } exp_t;
  exp_t sb_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
  endtask

  // Reference model: frames counted as a 13-bit timer, melody as lines since last toggle
  int m_timer, m_lines, m_note, m_ticks, m_aud, m_strobe;
  logic [15:0] m_lfsr;
  int half_period [16] = '{151,26,40,60,90,143,23,35,151,23,35,151,143,151,40,60};

  function automatic int voice_mix(int h, int v);
    int env_a, env_b, kick, snare, lead;
    env_a = 31 - (m_timer % 32);
    env_b = 31 - 2 * (m_timer % 16);
    kick  = (v < 255) && (h < env_a);
    snare = m_lfsr[0] && (h >= 32) && (h < 32 + env_b) && (((m_timer / 16) % 4) == 2);
    lead  = m_note && (h >= 64) && (h < 64 + env_b);
    return (kick || snare || lead) ? 1 : 0;
  endfunction

  task automatic model_edge(input int h, input int v, input bit p, input bit r);
    int line_t, frame_t, hp;
    if (!r) begin
      m_timer = 0; m_lines = 0; m_note = 0; m_ticks = 0;
      m_lfsr = SEED; m_aud = 0; m_strobe = 0;
      return;
    end
    line_t  = (h == 0) && !p;
    frame_t = line_t && (v == 0);
    m_aud    = p ? 0 : voice_mix(h, v);
    m_strobe = frame_t;
    if (line_t) begin
      // Counter runs 0..half+1 before wrapping, so a toggle lands every half+2 line ticks
      hp = half_period[(m_timer / 32) % 16];
      if (m_lines > hp) begin m_lines = 0; m_note = 1 - m_note; end
      else m_lines++;
      m_ticks++;
      if (m_ticks == NDIV) begin
        m_ticks = 0;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
    end
    if (frame_t) m_timer = (m_timer + 1) % 8192;
  endtask

  task automatic step(input int h, input int v, input bit p, input bit r);
    exp_t e;
    hpos = 10'(h); vpos = 10'(v); pause = p; rst_n = r;
    @(posedge clk); #1;
    model_edge(h, v, p, r);
    e.fc = m_timer / 2; e.prt = (m_timer / 256) % 8; e.nidx = (m_timer / 32) % 16;
    e.strobe = m_strobe; e.aud = m_aud; e.note = m_note; e.lfsr = int'(m_lfsr);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    step(7, 9, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("frame_count", int'(frame_count), e.fc);
      chk("part", int'(part), e.prt);
      chk("note_idx", int'(note_idx), e.nidx);
      chk("frame_strobe", int'(frame_strobe), e.strobe);
      chk("audio", int'(audio), e.aud);
      chk("note", int'(dut.r_note), e.note);
      chk("lfsr", int'(dut.r_lfsr), e.lfsr);
    end
  end

  initial begin
    int sv_timer, sv_note;
    logic [15:0] sv_lfsr;
    hpos = '0; vpos = '0; pause = 1'b0; rst_n = 1'b0;

    // Two frame ticks -> frame_count 1, frac 0, strobe one cycle after each
    do_reset();
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_lfsr", int'(dut.r_lfsr), int'(SEED));
    step(0, 0, 1'b0, 1'b1);
    chk("strobe_1", int'(frame_strobe), 1);
    step(5, 0, 1'b0, 1'b1);
    chk("strobe_gap", int'(frame_strobe), 0);
    step(0, 0, 1'b0, 1'b1);
    chk("strobe_2", int'(frame_strobe), 1);
    chk("two_ticks_fc", int'(frame_count), 1);
    chk("two_ticks_frac", int'(dut.r_timer[0]), 0);
    step(5, 0, 1'b0, 1'b1);
    chk("strobe_after", int'(frame_strobe), 0);

    // Kick window at timer 0: envelope 31 columns wide
    do_reset();
    step(30, 10, 1'b0, 1'b1);
    chk("kick_h30", int'(audio), 1);
    step(31, 10, 1'b0, 1'b1);
    chk("kick_h31", int'(audio), 0);
    step(30, 300, 1'b0, 1'b1);
    chk("kick_v300", int'(audio), 0);

    // 400 line ticks at timer 0 (note 0, half-period 151)
    do_reset();
    for (int k = 1; k <= 400; k++) begin
      step(0, 1, 1'b0, 1'b1);
      if (k == 152) chk("note_t152", int'(dut.r_note), 0);
      if (k == 153) chk("note_t153", int'(dut.r_note), 1);
      if (k == 305) chk("note_t305", int'(dut.r_note), 1);
      if (k == 306) chk("note_t306", int'(dut.r_note), 0);
    end
    chk("note_idx_lines", int'(note_idx), 0);

    // Full timer wrap: part steps every 128 frame_counts
    do_reset();
    for (int j = 0; j < 32; j++) begin
      chk("part_seq", int'(part), j % 8);
      chk("fc_seq", int'(frame_count), (j * 128) % 4096);
      repeat (256) step(0, 0, 1'b0, 1'b1);
    end
    chk("wrap_timer", int'(dut.r_timer), 0);

    // Pause across three frames
    do_reset();
    for (int k = 0; k < 40; k++) step((k % 3 == 0) ? 0 : 40, k % 5, 1'b0, 1'b1);
    sv_timer = m_timer; sv_note = m_note; sv_lfsr = m_lfsr;
    for (int f = 0; f < 3; f++) begin
      step(0, 0, 1'b1, 1'b1);
      chk("pause_audio", int'(audio), 0);
      chk("pause_strobe", int'(frame_strobe), 0);
      step(20, 20, 1'b1, 1'b1);
      chk("pause_audio_kick", int'(audio), 0);
      step(0, 7, 1'b1, 1'b1);
    end
    chk("pause_timer", int'(dut.r_timer), sv_timer);
    chk("pause_note", int'(dut.r_note), sv_note);
    chk("pause_lfsr", int'(dut.r_lfsr), int'(sv_lfsr));
    step(0, 0, 1'b0, 1'b1);
    chk("resume_timer", int'(dut.r_timer), (sv_timer + 1) % 8192);

    // Mid-frame reset with frame_count 77
    do_reset();
    repeat (154) step(0, 0, 1'b0, 1'b1);
    step(100, 200, 1'b0, 1'b1);
    chk("pre_rst_fc", int'(frame_count), 77);
    step(10, 200, 1'b1, 1'b0);
    chk("mid_rst_fc", int'(frame_count), 0);
    chk("mid_rst_lfsr", int'(dut.r_lfsr), int'(SEED));
    chk("mid_rst_audio", int'(audio), 0);

    // Randomized traffic, biased toward ticks and the audible columns
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      int h, v;
      bit p, r;
      h = ($urandom_range(0, 3) == 0) ? 0 :
          (($urandom_range(0, 7) == 0) ? $urandom_range(0, 799) : $urandom_range(0, 127));
      v = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 524);
      p = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 499) != 0);
      step(h, v, p, r);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
